bridge_unpack: RTL and testbench

BRIDGE_UNPACK -- requirements
Module: bridge_unpack

---
 rtl/bridge_pkg.sv | 14 +
 rtl/bridge_unpack.sv | 102 ++++++++++
 tb/tb_bridge_unpack.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the pack/unpack bridge pair.
// DEF_M / DEF_N are the default word and chunk widths agreed with the
// upstream packing stage. cnt_width() sizes a counter that must hold
// every value from 0 to the given bit count inclusive.
package bridge_pkg;

  localparam int DEF_M = 32;
  localparam int DEF_N = 8;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/bridge_unpack.sv
// bridge_unpack: splits a stream of M-bit words into N-bit chunks, MSB first.
// M need not be a multiple of N. A word flagged with last_i closes a packet.
// A final partial chunk is zero padded at the bottom and flagged with last_o.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   vld_i   din valid
//   din     input word (M bits, MSB earliest)
//   last_i  din is the final word of a packet (qualified by vld_i)
//   rdy_o   block accepts din this cycle
//   vld_o   dout holds a chunk
//   dout    output chunk (N bits, MSB earliest)
//   last_o  dout is the final chunk of a packet (qualified by vld_o)
//   rdy_i   downstream accepts dout this cycle
//
// Handshake: a word transfers on a cycle where vld_i && rdy_o. A chunk
// transfers on a cycle where vld_o && rdy_i. Both may happen in one cycle.
// rdy_o and vld_o depend only on registers (rdy_o is also gated by rst).
// Neither has a path from vld_i or rdy_i. Once vld_o is high, dout and
// last_o hold until the chunk is taken.
module bridge_unpack
  import bridge_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [M-1:0] din,
  input  logic         last_i,
  output logic         rdy_o,
  output logic         vld_o,
  output logic [N-1:0] dout,
  output logic         last_o,
  input  logic         rdy_i
);

  // Worst case fill: accept at cnt = 2N-1, then add a full word.
  localparam int B         = M + 2 * N - 1;
  localparam int CNT_WIDTH = cnt_width(B);

  // Left-aligned bit buffer. Bits below the fill level are always zero.
  // This invariant gives the zero padding of dout. It also lets a push
  // simply OR the new word into place.
  logic [B-1:0]         bits_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tail_q;

  logic                 push;
  logic                 pop;
  logic [CNT_WIDTH-1:0] pop_amt;
  logic [CNT_WIDTH-1:0] cnt_after_pop;
  logic [B-1:0]         bits_after_pop;
  logic [B-1:0]         din_aligned;

  assign rdy_o  = !rst && !tail_q && (cnt_q < CNT_WIDTH'(2 * N));
  assign vld_o  = (cnt_q >= CNT_WIDTH'(N)) || (tail_q && (cnt_q != '0));
  assign last_o = tail_q && (cnt_q <= CNT_WIDTH'(N));
  assign dout   = bits_q[B-1 -: N];

  assign push = vld_i && rdy_o;
  assign pop  = vld_o && rdy_i;

  // A same-cycle pop is applied first. The incoming word then lands
  // directly under whatever bits remain.
  always_comb begin
    pop_amt        = (cnt_q >= CNT_WIDTH'(N)) ? CNT_WIDTH'(N) : cnt_q;
    bits_after_pop = bits_q;
    cnt_after_pop  = cnt_q;
    if (pop) begin
      bits_after_pop = bits_q << pop_amt;
      cnt_after_pop  = cnt_q - pop_amt;
    end
    din_aligned = {din, {(B - M){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
      tail_q <= 1'b0;
    end else begin
      if (push) begin
        bits_q <= bits_after_pop | (din_aligned >> cnt_after_pop);
        cnt_q  <= cnt_after_pop + CNT_WIDTH'(M);
      end else begin
        bits_q <= bits_after_pop;
        cnt_q  <= cnt_after_pop;
      end
      // Push with tail set is impossible (rdy_o is low).
      // The last pop needs tail set. So the two branches never meet.
      if (pop && last_o) begin
        tail_q <= 1'b0;
      end else if (push && last_i) begin
        tail_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bridge_unpack.sv
// Bench for bridge_unpack. It uses three instances: M=32/N=8 (a),
// M=12/N=8 (b) and M=8/N=8 (c). All share one clock and reset.
// A table of per-cycle vectors drives the directed scenarios. A
// scoreboard then follows a backpressured multi-word stream on instance a.
module tb_bridge_unpack;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        vld_a, last_a, rdy_a, rdy_o_a, vld_o_a, last_o_a;
  logic [31:0] din_a;
  logic [7:0]  dout_a;
  logic        vld_b, last_b, rdy_b, rdy_o_b, vld_o_b, last_o_b;
  logic [11:0] din_b;
  logic [7:0]  dout_b;
  logic        vld_c, last_c, rdy_c, rdy_o_c, vld_o_c, last_o_c;
  logic [7:0]  din_c;
  logic [7:0]  dout_c;

  bridge_unpack #(.M(32), .N(8)) u_a (
    .clk(clk), .rst(rst), .vld_i(vld_a), .din(din_a), .last_i(last_a),
    .rdy_o(rdy_o_a), .vld_o(vld_o_a), .dout(dout_a), .last_o(last_o_a),
    .rdy_i(rdy_a)
  );
  bridge_unpack #(.M(12), .N(8)) u_b (
    .clk(clk), .rst(rst), .vld_i(vld_b), .din(din_b), .last_i(last_b),
    .rdy_o(rdy_o_b), .vld_o(vld_o_b), .dout(dout_b), .last_o(last_o_b),
    .rdy_i(rdy_b)
  );
  bridge_unpack #(.M(8), .N(8)) u_c (
    .clk(clk), .rst(rst), .vld_i(vld_c), .din(din_c), .last_i(last_c),
    .rdy_o(rdy_o_c), .vld_o(vld_o_c), .dout(dout_c), .last_o(last_o_c),
    .rdy_i(rdy_c)
  );

  // ---------------- check bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          sel;   // 0 = a (M32), 1 = b (M12), 2 = c (M8)
    logic        r;
    logic        vld;
    logic [31:0] din;
    logic        last;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_dout;
    logic        e_last;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input int sel, input logic r, input logic vld, input logic [31:0] din,
                   input logic last, input logic rdy, input logic e_vld,
                   input logic [7:0] e_dout, input logic e_last, input logic e_rdy);
    vec_t x;
    x.sel = sel; x.r = r; x.vld = vld; x.din = din; x.last = last; x.rdy = rdy;
    x.e_vld = e_vld; x.e_dout = e_dout; x.e_last = e_last; x.e_rdy = e_rdy;
    tbl.push_back(x);
  endtask

  task automatic idle_all();
    vld_a = 1'b0; din_a = '0; last_a = 1'b0; rdy_a = 1'b1;
    vld_b = 1'b0; din_b = '0; last_b = 1'b0; rdy_b = 1'b1;
    vld_c = 1'b0; din_c = '0; last_c = 1'b0; rdy_c = 1'b1;
  endtask

  // Drive one row, check outputs mid-cycle, then advance one clock.
  task automatic apply_vec(input int idx, input vec_t x);
    logic av, al, ar;
    logic [7:0] ad;
    idle_all();
    rst = x.r;
    case (x.sel)
      0: begin vld_a = x.vld; din_a = x.din;        last_a = x.last; rdy_a = x.rdy; end
      1: begin vld_b = x.vld; din_b = x.din[11:0];  last_b = x.last; rdy_b = x.rdy; end
      default: begin vld_c = x.vld; din_c = x.din[7:0]; last_c = x.last; rdy_c = x.rdy; end
    endcase
    #1;
    case (x.sel)
      0: begin av = vld_o_a; ad = dout_a; al = last_o_a; ar = rdy_o_a; end
      1: begin av = vld_o_b; ad = dout_b; al = last_o_b; ar = rdy_o_b; end
      default: begin av = vld_o_c; ad = dout_c; al = last_o_c; ar = rdy_o_c; end
    endcase
    chk($sformatf("vec%0d_vld_o", idx), 32'(av), 32'(x.e_vld));
    chk($sformatf("vec%0d_rdy_o", idx), 32'(ar), 32'(x.e_rdy));
    chk($sformatf("vec%0d_last_o", idx), 32'(al), 32'(x.e_last));
    if (x.e_vld) chk($sformatf("vec%0d_dout", idx), 32'(ad), 32'(x.e_dout));
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard (instance a) ----------------
  logic       sb_en = 1'b0;
  logic [8:0] exp_q[$];   // {last, chunk}

  always @(negedge clk) begin
    if (sb_en && !rst && vld_o_a && rdy_a) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_chunk", 32'({last_o_a, dout_a}), 32'h1ff);
      end else begin
        chk("sb_chunk", 32'({last_o_a, dout_a}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_a(input logic [31:0] w, input logic l);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    vld_a = 1'b1; din_a = w; last_a = l;
    while (!acc && guard < 200) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      #1;
      acc = rdy_o_a;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk("sb_push_timeout", 32'(guard), 32'(0));
    vld_a = 1'b0; last_a = 1'b0;
    for (int k = 3; k >= 0; k--) exp_q.push_back({(l && k == 0), w[k*8 +: 8]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy_forced_low", 32'(rdy_o_a), 32'(0));
    rst = 1'b0;
    #1;
    chk("rst_vld_a",  32'(vld_o_a),  32'(0));
    chk("rst_last_a", 32'(last_o_a), 32'(0));
    chk("rst_dout_a", 32'(dout_a),   32'(0));
    chk("rst_rdy_a",  32'(rdy_o_a),  32'(1));
    chk("rst_vld_b",  32'(vld_o_b),  32'(0));
    chk("rst_dout_b", 32'(dout_b),   32'(0));
    chk("rst_rdy_b",  32'(rdy_o_b),  32'(1));
    chk("rst_vld_c",  32'(vld_o_c),  32'(0));
    chk("rst_rdy_c",  32'(rdy_o_c),  32'(1));

    // M=32: two words, upstream holds vld; chunks on 8 consecutive cycles
    v(0,0,1,32'hAABBCCDD,0,1, 0,8'h00,0,1);
    v(0,0,1,32'h11223344,0,1, 1,8'hAA,0,0);
    v(0,0,1,32'h11223344,0,1, 1,8'hBB,0,0);
    v(0,0,1,32'h11223344,0,1, 1,8'hCC,0,0);
    v(0,0,1,32'h11223344,0,1, 1,8'hDD,0,1);
    v(0,0,0,32'h0,0,1,        1,8'h11,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h22,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h33,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h44,0,1);
    v(0,0,0,32'h0,0,1,        0,8'h00,0,1);
    // M=32: backpressure for 5 cycles, dout held, upstream stalled
    v(0,0,1,32'hAABBCCDD,0,0, 0,8'h00,0,1);
    for (int k = 0; k < 5; k++) v(0,0,1,32'h55667788,0,0, 1,8'hAA,0,0);
    v(0,0,1,32'h55667788,0,1, 1,8'hAA,0,0);
    v(0,0,1,32'h55667788,0,1, 1,8'hBB,0,0);
    v(0,0,1,32'h55667788,0,1, 1,8'hCC,0,0);
    v(0,0,1,32'h55667788,0,1, 1,8'hDD,0,1);
    v(0,0,0,32'h0,0,1,        1,8'h55,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h66,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h77,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h88,0,1);
    v(0,0,0,32'h0,0,1,        0,8'h00,0,1);
    // M=32: reset after the second chunk, then a clean word
    v(0,0,1,32'hAABBCCDD,0,1, 0,8'h00,0,1);
    v(0,0,0,32'h0,0,1,        1,8'hAA,0,0);
    v(0,0,0,32'h0,0,1,        1,8'hBB,0,0);
    v(0,1,0,32'h0,0,1,        1,8'hCC,0,0);
    v(0,0,1,32'h01020304,0,1, 0,8'h00,0,1);
    v(0,0,0,32'h0,0,1,        1,8'h01,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h02,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h03,0,0);
    v(0,0,0,32'h0,0,1,        1,8'h04,0,1);
    v(0,0,0,32'h0,0,1,        0,8'h00,0,1);
    // M=12: reset mid-packet with tail pending discards everything
    v(1,0,1,32'hABC,1,0, 0,8'h00,0,1);
    v(1,0,0,32'h0,0,0,   1,8'hAB,0,0);
    v(1,1,0,32'h0,0,0,   1,8'hAB,0,0);
    v(1,0,0,32'h0,0,1,   0,8'h00,0,1);
    // M=12: 0xABC, 0xDEF -> AB, CD, EF, then empty
    v(1,0,1,32'hABC,0,1, 0,8'h00,0,1);
    v(1,0,1,32'hDEF,0,1, 1,8'hAB,0,1);
    v(1,0,0,32'h0,0,1,   1,8'hCD,0,0);
    v(1,0,0,32'h0,0,1,   1,8'hEF,0,1);
    v(1,0,0,32'h0,0,1,   0,8'h00,0,1);
    // M=12: single last word -> AB then zero-padded C0 with last_o
    v(1,0,1,32'hABC,1,1, 0,8'h00,0,1);
    v(1,0,0,32'h0,0,0,   1,8'hAB,0,0);
    v(1,0,0,32'h0,0,1,   1,8'hAB,0,0);
    v(1,0,0,32'h0,0,1,   1,8'hC0,1,0);
    v(1,0,0,32'h0,0,1,   0,8'h00,0,1);
    // M=8: last on second word only; next packet starts cleanly
    v(2,0,1,32'h11,0,1, 0,8'h00,0,1);
    v(2,0,1,32'h22,1,1, 1,8'h11,0,1);
    v(2,0,1,32'h33,0,1, 1,8'h22,1,0);
    v(2,0,1,32'h33,0,1, 0,8'h00,0,1);
    v(2,0,0,32'h0,0,1,  1,8'h33,0,1);
    v(2,0,0,32'h0,0,1,  0,8'h00,0,1);

    foreach (tbl[i]) apply_vec(i, tbl[i]);

    // Scoreboard stream on instance a with random downstream stalls
    idle_all();
    rst   = 1'b0;
    sb_en = 1'b1;
    push_a(32'hDEADBEEF, 1'b0);
    push_a(32'h0BADF00D, 1'b0);
    push_a(32'h12345678, 1'b1);
    push_a(32'hCAFEF00D, 1'b1);
    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
        rdy_a = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        guard++;
      end
    end
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    rdy_a = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b0;
    chk("sb_idle_vld", 32'(vld_o_a), 32'(0));
    chk("sb_idle_rdy", 32'(rdy_o_a), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
